// File: rtl/rgb_to_yuv_encoder.sv
// Frame encoder: reads interleaved RGB pixels from SRAM in groups of four, converts them to BT.601
// studio-range Y plus pair-averaged U/V, and writes the planes back in the layout the decoder consumes.
module rgb_to_yuv_encoder #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter int          NUM_PIXELS = 76800
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_WY0  = 3'd3;
    localparam logic [2:0] S_WY1  = 3'd4;
    localparam logic [2:0] S_WU   = 3'd5;
    localparam logic [2:0] S_WV   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    // Y pointer value at the start of the final group.
    localparam logic [17:0] Y_LAST = Y_BASE + 18'(NUM_PIXELS / 2 - 2);

    function automatic logic signed [31:0] zext8(input logic [7:0] b);
        return $signed({24'd0, b});
    endfunction

    function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v < 32'sd0) begin
            r = 8'd0;
        end else if (v > 32'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic [2:0]  calc_cnt_q, calc_cnt_d;
    logic [17:0] rgb_ptr_q, rgb_ptr_d;
    logic [17:0] y_ptr_q, y_ptr_d;
    logic [17:0] u_ptr_q, u_ptr_d;
    logic [17:0] v_ptr_q, v_ptr_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        rd_p1_q, rd_p2_q;
    logic [2:0]  cap_idx_q;
    logic [15:0] w_q [0:5];
    logic [7:0]  y_q [0:3];
    logic [7:0]  u_q [0:1];
    logic [7:0]  v_q [0:1];

    logic [7:0]  px_r_s [0:3];
    logic [7:0]  px_g_s [0:3];
    logic [7:0]  px_b_s [0:3];
    logic [1:0]  pix_idx_s;
    logic        pair_idx_s;
    logic        is_uv_s;
    logic signed [31:0] op_a_s, op_b_s, op_c_s;
    logic signed [31:0] k_a_s, k_b_s, k_c_s;
    logic signed [31:0] sum_s, res_s;
    logic [7:0]  res8_s;

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign busy            = busy_q;
    assign done            = done_q;

    // Unpack the six captured words {R0,G0},{B0,R1},{G1,B1},{R2,G2},{B2,R3},{G3,B3} into pixels.
    always_comb begin
        px_r_s[0] = w_q[0][15:8];
        px_g_s[0] = w_q[0][7:0];
        px_b_s[0] = w_q[1][15:8];
        px_r_s[1] = w_q[1][7:0];
        px_g_s[1] = w_q[2][15:8];
        px_b_s[1] = w_q[2][7:0];
        px_r_s[2] = w_q[3][15:8];
        px_g_s[2] = w_q[3][7:0];
        px_b_s[2] = w_q[4][15:8];
        px_r_s[3] = w_q[4][7:0];
        px_g_s[3] = w_q[5][15:8];
        px_b_s[3] = w_q[5][7:0];
    end

    // Calc step order: Y p0, Y p1, U pair0, V pair0, Y p2, Y p3, U pair1, V pair1.
    // This follows data arrival so the last word is not needed before step 5.
    always_comb begin
        pix_idx_s  = {calc_cnt_q[2], calc_cnt_q[0]};
        pair_idx_s = calc_cnt_q[2];
        is_uv_s    = calc_cnt_q[1];
        op_a_s     = 32'sd0;
        op_b_s     = 32'sd0;
        op_c_s     = 32'sd0;
        k_a_s      = 32'sd66;
        k_b_s      = 32'sd129;
        k_c_s      = 32'sd25;
        if (!is_uv_s) begin
            op_a_s = zext8(px_r_s[pix_idx_s]);
            op_b_s = zext8(px_g_s[pix_idx_s]);
            op_c_s = zext8(px_b_s[pix_idx_s]);
        end else begin
            op_a_s = zext8(px_r_s[{pair_idx_s, 1'b0}]) + zext8(px_r_s[{pair_idx_s, 1'b1}]);
            op_b_s = zext8(px_g_s[{pair_idx_s, 1'b0}]) + zext8(px_g_s[{pair_idx_s, 1'b1}]);
            op_c_s = zext8(px_b_s[{pair_idx_s, 1'b0}]) + zext8(px_b_s[{pair_idx_s, 1'b1}]);
            if (!calc_cnt_q[0]) begin
                k_a_s = -32'sd38;
                k_b_s = -32'sd74;
                k_c_s = 32'sd112;
            end else begin
                k_a_s = 32'sd112;
                k_b_s = -32'sd94;
                k_c_s = -32'sd18;
            end
        end
    end

    // Three shared multipliers, rounding, scaling and clamping.
    always_comb begin
        if (is_uv_s) begin
            sum_s = op_a_s * k_a_s + op_b_s * k_b_s + op_c_s * k_c_s + 32'sd256;
            res_s = (sum_s >>> 9) + 32'sd128;
        end else begin
            sum_s = op_a_s * k_a_s + op_b_s * k_b_s + op_c_s * k_c_s + 32'sd128;
            res_s = (sum_s >>> 8) + 32'sd16;
        end
        res8_s = clamp_u8(res_s);
    end

    // Read-return pipeline: marks the cycle in which each issued read's data is on the bus.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            rd_p1_q <= 1'b0;
            rd_p2_q <= 1'b0;
        end else begin
            rd_p1_q <= (state_q == S_RD);
            rd_p2_q <= rd_p1_q;
        end
    end

    // Capture returning RGB words in issue order.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            cap_idx_q <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                w_q[i] <= 16'd0;
            end
        end else if (rd_p2_q) begin
            w_q[cap_idx_q] <= SRAM_read_data;
            cap_idx_q      <= (cap_idx_q == 3'd5) ? 3'd0 : cap_idx_q + 3'd1;
        end else begin
            cap_idx_q <= cap_idx_q;
        end
    end

    // Store one converted sample per calc step.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= 8'd0;
            end
            for (int i = 0; i < 2; i++) begin
                u_q[i] <= 8'd0;
                v_q[i] <= 8'd0;
            end
        end else if (state_q == S_CALC) begin
            if (!is_uv_s) begin
                y_q[pix_idx_s] <= res8_s;
            end else if (!calc_cnt_q[0]) begin
                u_q[pair_idx_s] <= res8_s;
            end else begin
                v_q[pair_idx_s] <= res8_s;
            end
        end else begin
            y_q[0] <= y_q[0];
        end
    end

    // Sequencer next-state: reads, calc, then the four plane writes of each group.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        calc_cnt_d = calc_cnt_q;
        rgb_ptr_d  = rgb_ptr_q;
        y_ptr_d    = y_ptr_q;
        u_ptr_d    = u_ptr_q;
        v_ptr_d    = v_ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RD;
                    busy_d    = 1'b1;
                    rd_cnt_d  = 3'd0;
                    rgb_ptr_d = RGB_BASE;
                    y_ptr_d   = Y_BASE;
                    u_ptr_d   = U_BASE;
                    v_ptr_d   = V_BASE;
                    addr_d    = RGB_BASE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (rd_cnt_q == 3'd5) begin
                    state_d    = S_CALC;
                    calc_cnt_d = 3'd0;
                    rgb_ptr_d  = rgb_ptr_q + 18'd6;
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    addr_d   = rgb_ptr_q + 18'(rd_cnt_q) + 18'd1;
                end
            end
            S_CALC: begin
                if (calc_cnt_q == 3'd7) begin
                    state_d = S_WY0;
                    addr_d  = y_ptr_q;
                    wdata_d = {y_q[0], y_q[1]};
                    we_n_d  = 1'b0;
                end else begin
                    calc_cnt_d = calc_cnt_q + 3'd1;
                end
            end
            S_WY0: begin
                state_d = S_WY1;
                addr_d  = y_ptr_q + 18'd1;
                wdata_d = {y_q[2], y_q[3]};
                we_n_d  = 1'b0;
            end
            S_WY1: begin
                state_d = S_WU;
                addr_d  = u_ptr_q;
                wdata_d = {u_q[0], u_q[1]};
                we_n_d  = 1'b0;
            end
            S_WU: begin
                state_d = S_WV;
                addr_d  = v_ptr_q;
                wdata_d = {v_q[0], v_q[1]};
                we_n_d  = 1'b0;
            end
            S_WV: begin
                y_ptr_d = y_ptr_q + 18'd2;
                u_ptr_d = u_ptr_q + 18'd1;
                v_ptr_d = v_ptr_q + 18'd1;
                if (y_ptr_q == Y_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = S_RD;
                    rd_cnt_d = 3'd0;
                    addr_d   = rgb_ptr_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and registered SRAM-side outputs.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= 3'd0;
            calc_cnt_q <= 3'd0;
            rgb_ptr_q  <= RGB_BASE;
            y_ptr_q    <= Y_BASE;
            u_ptr_q    <= U_BASE;
            v_ptr_q    <= V_BASE;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            we_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            calc_cnt_q <= calc_cnt_d;
            rgb_ptr_q  <= rgb_ptr_d;
            y_ptr_q    <= y_ptr_d;
            u_ptr_q    <= u_ptr_d;
            v_ptr_q    <= v_ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Scoreboard bench for rgb_to_yuv_encoder on a 5-group frame: expected SRAM writes are queued
// at stimulus time and a monitor pops and compares every write the DUT issues.
module tb_rgb_to_yuv_encoder;

    localparam int          NPIX  = 20;
    localparam int          NGRP  = NPIX / 4;
    localparam logic [17:0] RGB_B = 18'd146944;
    localparam logic [17:0] U_B   = 18'd38400;
    localparam logic [17:0] V_B   = 18'd57600;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;

    logic [15:0] rgb_mem [0:29];
    logic [15:0] rd1 = 16'd0;
    logic [15:0] rd2 = 16'd0;
    int          rd_idx;
    wr_t         exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    rgb_to_yuv_encoder #(.NUM_PIXELS(NPIX)) dut (
        .CLOCK_50_I      (clk),
        .Resetn          (rstn),
        .start           (start),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy),
        .done            (done)
    );

    // SRAM model: read data for the address of cycle N appears in cycle N+2.
    assign rd_idx = int'(SRAM_address) - int'(RGB_B);
    always @(posedge clk) begin
        if (rd_idx >= 0 && rd_idx < 30) rd1 <= rgb_mem[rd_idx];
        else rd1 <= 16'h0000;
        rd2 <= rd1;
    end
    assign SRAM_read_data = rd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT issues must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rstn && !SRAM_we_n) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, want no write", SRAM_address, SRAM_write_data);
                end else begin
                    e = exp_q.pop_front();
                    if (SRAM_address !== e.a || SRAM_write_data !== e.d) begin
                        n_err++;
                        $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                                 SRAM_address, SRAM_write_data, e.a, e.d);
                    end
                    if (SRAM_address >= RGB_B) begin
                        n_err++;
                        $display("FAIL write_range: got addr=%h, want below %h", SRAM_address, RGB_B);
                    end
                end
            end
            if (rstn && done) done_cnt++;
        end
    end

    task automatic push_group(input int g, input logic [15:0] y0, input logic [15:0] y1,
                              input logic [15:0] u, input logic [15:0] v);
        wr_t e;
        e.a = 18'(2 * g);       e.d = y0; exp_q.push_back(e);
        e.a = 18'(2 * g + 1);   e.d = y1; exp_q.push_back(e);
        e.a = U_B + 18'(g);     e.d = u;  exp_q.push_back(e);
        e.a = V_B + 18'(g);     e.d = v;  exp_q.push_back(e);
    endtask

    task automatic load_group(input int g, input logic [95:0] ws);
        for (int k = 0; k < 6; k++) rgb_mem[g * 6 + k] = ws[95 - 16 * k -: 16];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(SRAM_address), 32'd0);
        chk({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
        chk({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic run_frame(input bit poke_start);
        int cycles;
        int done_before;
        done_before = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        cycles = 0;
        while (done_cnt == done_before && cycles < 24 * NGRP + 20) begin
            @(posedge clk); #1;
            cycles++;
            start = (poke_start && cycles == 20) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("done_within_budget", 32'(cycles <= 24 * NGRP), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - done_before), 32'd1);
        chk("busy_low_after", 32'(busy), 32'd0);
        chk("we_n_idle_after", 32'(SRAM_we_n), 32'd1);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 30; i++) rgb_mem[i] = 16'h0000;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // All-zero frame.
        for (int g = 0; g < NGRP; g++) push_group(g, 16'h1010, 16'h1010, 16'h8080, 16'h8080);
        run_frame(1'b0);

        // Mixed directed frame: black, white, red, half black/half white, green.
        load_group(0, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        load_group(1, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        load_group(2, {16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000});
        load_group(3, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        load_group(4, {16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000, 16'hFF00});
        push_group(0, 16'h1010, 16'h1010, 16'h8080, 16'h8080);
        push_group(1, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
        push_group(2, 16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0);
        push_group(3, 16'h1010, 16'hEBEB, 16'h8080, 16'h8080);
        push_group(4, 16'h9090, 16'h9090, 16'h3636, 16'h2222);
        run_frame(1'b1);

        // Abort a zero frame mid-group, then rerun it from pixel 0.
        for (int i = 0; i < 30; i++) rgb_mem[i] = 16'h0000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("abort_no_pending", 32'(exp_q.size()), 32'd0);
        for (int g = 0; g < NGRP; g++) push_group(g, 16'h1010, 16'h1010, 16'h8080, 16'h8080);
        run_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
